// File: rtl/ccu_arb_pkg.sv
// Shared types and helpers for the CCU transaction arbiter.
// Holds the FSM state encoding and the select-index width rule.
package ccu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } arb_state_e;

   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ccu_txn_arbiter_if.sv
// Request/grant bundle between the core ACE ports, the arbiter and the CCU.
// The master modport is the arbiter side; slave is the core/CCU environment.
interface ccu_txn_arbiter_if
   import ccu_arb_pkg::*;
#(
   parameter  int NoPorts = 4,
   localparam int IdxW    = idx_w(NoPorts)
);

   logic [NoPorts-1:0] req_valid_i;
   logic [NoPorts-1:0] req_ready_o;
   logic               ccu_valid_o;
   logic               ccu_ready_i;
   logic               ccu_done_i;
   logic [IdxW-1:0]    sel_o;
   logic               sel_valid_o;
   logic               timeout_o;

   modport master (
      input  req_valid_i, ccu_ready_i, ccu_done_i,
      output req_ready_o, ccu_valid_o, sel_o, sel_valid_o, timeout_o
   );

   modport slave (
      output req_valid_i, ccu_ready_i, ccu_done_i,
      input  req_ready_o, ccu_valid_o, sel_o, sel_valid_o, timeout_o
   );

endinterface

// File: rtl/ccu_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Works on a doubled request vector whose low copy is masked below ptr.
module ccu_rr_pick
   import ccu_arb_pkg::*;
#(
   parameter  int NoPorts = 4,
   localparam int IdxW    = idx_w(NoPorts)
) (
   input  logic [NoPorts-1:0] req_i,
   input  logic [IdxW-1:0]    ptr_i,
   output logic [IdxW-1:0]    idx_o,
   output logic               any_o
);

   localparam int DblW = 2 * NoPorts;

   logic [DblW-1:0] dbl;
   logic            found;

   always_comb begin
      dbl = {req_i, req_i};
      for (int i = 0; i < NoPorts; i++) begin
         if (i < int'(ptr_i)) dbl[i] = 1'b0;
      end
      // A hit in the upper copy is a wrapped hit below ptr.
      idx_o = '0;
      found = 1'b0;
      for (int i = 0; i < DblW; i++) begin
         if (dbl[i] && !found) begin
            found = 1'b1;
            idx_o = IdxW'(i % NoPorts);
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/ccu_txn_arbiter.sv
// Round-robin arbiter sharing the CCU request path among NoPorts cores.
// Grant is held from arbitration through CCU completion, with a completion watchdog.
module ccu_txn_arbiter
   import ccu_arb_pkg::*;
#(
   parameter int NoPorts       = 4,
   parameter int TimeoutCycles = 1024
) (
   input  logic               clk_i,
   input  logic               rst_i,
   ccu_txn_arbiter_if.master  bus
);

   localparam int IdxW = idx_w(NoPorts);
   localparam int CntW = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NoPorts - 1);

   if (NoPorts < 1 || NoPorts > 16) begin : g_bad_ports
      $error("ccu_txn_arbiter: NoPorts must be in 1..16");
   end
   if (TimeoutCycles < 1) begin : g_bad_timeout
      $error("ccu_txn_arbiter: TimeoutCycles must be >= 1");
   end

   arb_state_e          state_q, state_d;
   logic [IdxW-1:0]     ptr_q, ptr_d;
   logic [IdxW-1:0]     sel_q, sel_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                sel_valid_q;
   logic [IdxW-1:0]     pick_idx;
   logic                pick_any;
   logic                ccu_valid;
   logic [NoPorts-1:0]  req_ready;
   logic                timeout;

   ccu_rr_pick #(
      .NoPorts (NoPorts)
   ) u_pick (
      .req_i (bus.req_valid_i),
      .ptr_i (ptr_q),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         sel_q       <= '0;
         cnt_q       <= '0;
         sel_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         sel_valid_q <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      ccu_valid = 1'b0;
      req_ready = '0;
      timeout   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               sel_d   = pick_idx;
               state_d = REQ;
            end
         end
         REQ: begin
            // A done arriving with the handshake belongs to nothing yet; ignore it.
            ccu_valid = 1'b1;
            if (bus.ccu_ready_i) begin
               for (int i = 0; i < NoPorts; i++) begin
                  req_ready[i] = (IdxW'(i) == sel_q);
               end
               state_d = WAIT;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (bus.ccu_done_i) begin
               state_d = IDLE;
               cnt_d   = '0;
               ptr_d   = (sel_q == LastIdx) ? '0 : sel_q + IdxW'(1);
            end else if (cnt_q != CntMax) begin
               cnt_d   = cnt_q + CntW'(1);
               timeout = (cnt_q == CntMax - CntW'(1));
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ccu_valid_o = ccu_valid;
   assign bus.req_ready_o = req_ready;
   assign bus.sel_o       = sel_q;
   assign bus.sel_valid_o = sel_valid_q;
   assign bus.timeout_o   = timeout;

   // The cycle right after reset is exempt: the CCU may still finish a flushed transaction.
   a_done_only_in_wait: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.ccu_done_i |-> (state_q == WAIT) || $past(rst_i))
      else $error("ccu_txn_arbiter: ccu_done_i outside WAIT");

   a_req_held_in_req: assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == REQ) |-> bus.req_valid_i[sel_q])
      else $error("ccu_txn_arbiter: granted request dropped before ready");

endmodule

// File: tb/tb_ccu_txn_arbiter.sv
// Bench for ccu_txn_arbiter: table of transactions plus a reset-in-WAIT sequence.
// Expected grants are queued at stimulus time and popped on each CCU handshake.
module tb_ccu_txn_arbiter;

   localparam int NP = 4;
   localparam int TO = 8;

   typedef struct {
      logic [3:0] req;
      int         rdy_wait;
      int         done_wait;
      logic [1:0] exp;
   } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;
   logic [1:0] exp_q[$];
   vec_t tbl[13];

   ccu_txn_arbiter_if #(.NoPorts(NP)) bus ();

   ccu_txn_arbiter #(
      .NoPorts       (NP),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Scoreboard: every CCU handshake must match the oldest queued grant.
   always @(negedge clk) begin
      if (!rst && bus.req_ready_o != '0) begin
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_grant", 32'(bus.req_ready_o), 32'(0));
         end else begin
            logic [1:0] e;
            e = exp_q.pop_front();
            chk("sb_sel", 32'(bus.sel_o), 32'(e));
            chk("sb_ready_onehot", 32'(bus.req_ready_o), 32'(1) << e);
         end
      end
   end

   // Called at #1 after a rising edge with the DUT in IDLE; returns the same way.
   task automatic txn(input logic [3:0] req, input int rdy_wait, input int done_wait,
                      input logic [1:0] exp);
      bus.req_valid_i = req;
      bus.ccu_ready_i = (rdy_wait == 0);
      exp_q.push_back(exp);
      @(posedge clk); #1;
      chk("req_ccu_valid", 32'(bus.ccu_valid_o), 32'(1));
      chk("req_sel_valid", 32'(bus.sel_valid_o), 32'(1));
      for (int k = 0; k < rdy_wait; k++) begin
         chk("bp_ccu_valid", 32'(bus.ccu_valid_o), 32'(1));
         chk("bp_req_ready", 32'(bus.req_ready_o), 32'(0));
         chk("bp_sel", 32'(bus.sel_o), 32'(exp));
         if (k == 1) bus.req_valid_i = ~req | (4'b0001 << exp);
         @(posedge clk); #1;
      end
      bus.ccu_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.ccu_ready_i = 1'b0;
      chk("wait_ccu_valid", 32'(bus.ccu_valid_o), 32'(0));
      chk("wait_req_ready", 32'(bus.req_ready_o), 32'(0));
      for (int k = 0; k < done_wait; k++) begin
         chk("wait_sel_valid", 32'(bus.sel_valid_o), 32'(1));
         chk("wait_timeout", 32'(bus.timeout_o), (k == TO - 1) ? 32'(1) : 32'(0));
         @(posedge clk); #1;
      end
      bus.ccu_done_i = 1'b1;
      @(posedge clk); #1;
      bus.ccu_done_i = 1'b0;
      chk("done_sel_valid", 32'(bus.sel_valid_o), 32'(0));
      chk("done_ccu_valid", 32'(bus.ccu_valid_o), 32'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst = 1'b1;
      bus.req_valid_i = '0;
      bus.ccu_ready_i = 1'b0;
      bus.ccu_done_i  = 1'b0;

      // {req, ready delay, WAIT cycles before done, expected grant}
      tbl[0]  = '{4'b0010, 0, 2,  2'd1};  // single requester, ptr -> 2
      tbl[1]  = '{4'b1111, 0, 0,  2'd2};
      tbl[2]  = '{4'b1111, 0, 0,  2'd3};
      tbl[3]  = '{4'b1111, 0, 0,  2'd0};
      tbl[4]  = '{4'b1111, 0, 0,  2'd1};
      tbl[5]  = '{4'b1111, 0, 0,  2'd2};
      tbl[6]  = '{4'b0101, 0, 1,  2'd0};  // ptr=3 wraps to 0
      tbl[7]  = '{4'b0101, 0, 0,  2'd2};  // ptr=1 skips to 2
      tbl[8]  = '{4'b1000, 5, 1,  2'd3};  // backpressure, other ports toggle
      tbl[9]  = '{4'b0110, 0, 3,  2'd1};
      tbl[10] = '{4'b0001, 0, 12, 2'd0};  // watchdog fires once, then done
      tbl[11] = '{4'b1001, 0, 0,  2'd3};
      tbl[12] = '{4'b1001, 0, 0,  2'd0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ccu_valid", 32'(bus.ccu_valid_o), 32'(0));
      chk("rst_req_ready", 32'(bus.req_ready_o), 32'(0));
      chk("rst_sel_valid", 32'(bus.sel_valid_o), 32'(0));
      chk("rst_timeout",   32'(bus.timeout_o),   32'(0));
      chk("rst_sel",       32'(bus.sel_o),       32'(0));
      rst = 1'b0;

      for (int i = 0; i < 13; i++) begin
         txn(tbl[i].req, tbl[i].rdy_wait, tbl[i].done_wait, tbl[i].exp);
      end

      // Reset while in WAIT, then a stray done right after it.
      bus.req_valid_i = 4'b0100;
      bus.ccu_ready_i = 1'b1;
      exp_q.push_back(2'd2);
      @(posedge clk); #1;
      chk("mr_req_sel", 32'(bus.sel_o), 32'(2));
      @(posedge clk); #1;
      bus.ccu_ready_i = 1'b0;
      bus.req_valid_i = '0;
      @(posedge clk); #1;
      chk("mr_in_wait", 32'(bus.sel_valid_o), 32'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mr_sel_valid", 32'(bus.sel_valid_o), 32'(0));
      chk("mr_ccu_valid", 32'(bus.ccu_valid_o), 32'(0));
      chk("mr_sel",       32'(bus.sel_o),       32'(0));
      bus.ccu_done_i = 1'b1;
      @(posedge clk); #1;
      bus.ccu_done_i = 1'b0;
      chk("mr_done_ignored_sel_valid", 32'(bus.sel_valid_o), 32'(0));
      chk("mr_done_ignored_ccu_valid", 32'(bus.ccu_valid_o), 32'(0));
      txn(4'b1111, 0, 0, 2'd0);

      chk("sb_leftover", 32'(exp_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
